timer_irq_service_master: RTL and testbench
===========================================

// Module: timer_irq_service_master
// PURPOSE
// - Avalon-MM master that drives the interval-timer slave register map (status@0, control@1, period_l@2,
//   period_h@3, snap_l@4, snap_h@5; 16-bit data, no waitrequest, readdata registered 1 cycle).
// - Programs period, starts the timer continuous with IRQ enabled, services each IRQ in hardware
//   (clear status, capture and read snapshot), counts ticks. Sits between control logic and the timer, no CPU.
// PARAMETERS
// - TICK_W   32   width of tick_count
// - RD_LAT   1    slave read latency in clocks (cycles from address to valid readdata)
// PORTS
// - clk          in   1       system clock; single clock domain
// - reset_n      in   1       asynchronous, active-low reset
// - cmd_start    in   1       1-cycle pulse: (re)program period and start timer
// - cmd_stop     in   1       1-cycle pulse: stop timer
// - cfg_period   in   32      period value; sampled on cmd_start
// - address      out  3       Avalon master address to timer
// - chipselect   out  1       Avalon chip select
// - write_n      out  1       Avalon write strobe, active low
// - writedata    out  16      Avalon write data
// - readdata     in   16      Avalon read data from timer
// - timer_irq    in   1       timer interrupt, level, high until status written
// - busy         out  1       high in any state except IDLE and RUN
// - running      out  1       high while timer programmed and started
// - tick_pulse   out  1       1-cycle pulse per serviced IRQ, with snap_value valid
// - tick_count   out  TICK_W  serviced IRQ count; wraps all-ones -> 0
// - snap_value   out  32      counter snapshot captured at last service
// BEHAVIOUR
// - Reset: state IDLE; chipselect=0, write_n=1, address=0, writedata=0, busy=0, running=0, tick_pulse=0,
//   tick_count=0, snap_value=0, period latch=0.
// - Each bus write = exactly one cycle chipselect=1, write_n=0; all other cycles chipselect=0, write_n=1.
// - Read: chipselect=1, write_n=1, address held RD_LAT+1 cycles; readdata sampled on last of those cycles.
// - FSM: IDLE -cmd_start-> WR_PL(addr2, period[15:0]) -> WR_PH(addr3, period[31:16])
//   -> WR_CTRL(addr1, 16'h0007: ITO|CONT|START) -> RUN (running=1).
// - WR_CTRL comes after WR_PH: period writes force timer reload/stop, START must follow them.
// - RUN: timer_irq=1 -> CLR_ST(addr0, data 0) -> SNAP(addr4 write, data 0, captures counter)
//   -> RD_SL(addr4) -> RD_SH(addr5) -> DONE: snap_value={hi,lo}, tick_count+1, tick_pulse=1 -> RUN.
// - Any state -cmd_stop-> STOP(addr1, 16'h0008) -> IDLE, running=0; stop is completed after the in-flight
//   bus cycle (never truncates a held read); tick_pulse suppressed if stop preempts DONE.
// - cmd_start in RUN: re-latch cfg_period, go WR_PL (reprogram); tick_count not cleared.
// - cmd_start while busy: ignored. cmd_start and cmd_stop same cycle: stop wins.
// - timer_irq ignored in IDLE/STOP; irq asserted during service sequence is handled after return to RUN
//   (level still high if set again after CLR_ST).
// - Latencies: cmd_start -> running=1 in 4 cycles; irq rise -> tick_pulse in 5+2*(RD_LAT+1) cycles.
// - cfg_period=0 accepted and written verbatim (timer then irqs every cycle; master rate-limits by FSM).
// TESTING
// - Reset mid-RD_SH: assert reset_n=0 -> all outputs to reset values same cycle, FSM IDLE, no bus cycle.
// - cmd_start, cfg_period=32'h0001_869F -> writes (2,869F),(3,0001),(1,0007) on 3 consecutive cycles,
//   running=1.
// - Slave model fires irq, snapshot 32'h0000_1234 -> writes (0,0),(4,0), reads 4,5;
//   tick_pulse, snap_value=32'h0000_1234, tick_count=1, irq deasserted.
// - cmd_stop during RD_SL -> read completes, then write (1,0008), IDLE, no tick_pulse, tick_count unchanged.
// - Preload tick_count to all-ones via 2^TICK_W-1 irqs (TICK_W=4 build: 15) -> next service gives 0.
// - cmd_start and cmd_stop same cycle in RUN -> only (1,0008) written; cmd_start in WR_PH -> ignored.

Source files
------------

// File: rtl/timer_irq_service_master.sv
// timer_irq_service_master
// Avalon-MM master for the interval-timer slave. It programs the period,
// starts the timer in continuous mode with its interrupt enabled, and services
// every interrupt in hardware: clear status, request a counter snapshot, read
// both snapshot halves, then publish the snapshot and bump a tick counter.
// The block runs without a CPU.
module timer_irq_service_master #(
  parameter int TICK_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic [31:0]       cfg_period,
  output logic [2:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [15:0]       writedata,
  input  logic [15:0]       readdata,
  input  logic              timer_irq,
  output logic              busy,
  output logic              running,
  output logic              tick_pulse,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value
);

  // Timer slave register map (word addresses).
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  // Control words: ITO | CONT | START to run, STOP to halt.
  localparam logic [15:0] CTRL_RUN  = 16'h0007;
  localparam logic [15:0] CTRL_STOP = 16'h0008;

  // Sequencer states. Every write state lasts exactly one cycle; the two
  // read states are held for RD_LAT+1 cycles.
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WR_PL   = 4'd1;
  localparam logic [3:0] S_WR_PH   = 4'd2;
  localparam logic [3:0] S_WR_CTRL = 4'd3;
  localparam logic [3:0] S_RUN     = 4'd4;
  localparam logic [3:0] S_CLR_ST  = 4'd5;
  localparam logic [3:0] S_SNAP    = 4'd6;
  localparam logic [3:0] S_RD_SL   = 4'd7;
  localparam logic [3:0] S_RD_SH   = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;
  localparam logic [3:0] S_STOP    = 4'd10;

  // Read-hold counter: counts 0..RD_LAT while a read address is held.
  localparam int              RC_W    = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(RD_LAT);

  logic [3:0]      state_q;
  logic [3:0]      state_d;
  logic [RC_W-1:0] rd_cnt_q;
  logic            stop_pend_q;
  logic            irq_q;
  logic [31:0]     period_q;
  logic [15:0]     snap_lo_q;
  logic [15:0]     snap_hi_q;

  logic            is_read;
  logic            rd_last;
  logic            cycle_end;
  logic            stop_req;

  // A read is only complete on the last cycle of its hold window; every other
  // state finishes its bus activity (if any) in a single cycle.
  assign is_read   = (state_q == S_RD_SL) || (state_q == S_RD_SH);
  assign rd_last   = (rd_cnt_q == RD_LAST);
  assign cycle_end = !is_read || rd_last;

  // A stop seen mid-read is remembered until the read window closes, so a
  // held read is never cut short.
  assign stop_req  = cmd_stop || stop_pend_q;

  assign busy      = (state_q != S_IDLE) && (state_q != S_RUN);

  // Next-state selection: stop has priority over everything, then start,
  // then interrupt service.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    if (stop_req && (state_q != S_STOP) && cycle_end) begin
      state_d = S_STOP;
    end else begin
      case (state_q)
        S_IDLE:    if (cmd_start) state_d = S_WR_PL;
        S_WR_PL:   state_d = S_WR_PH;
        S_WR_PH:   state_d = S_WR_CTRL;
        S_WR_CTRL: state_d = S_RUN;
        S_RUN: begin
          if (cmd_start)  state_d = S_WR_PL;
          else if (irq_q) state_d = S_CLR_ST;
        end
        S_CLR_ST:  state_d = S_SNAP;
        S_SNAP:    state_d = S_RD_SL;
        S_RD_SL:   if (rd_last) state_d = S_RD_SH;
        S_RD_SH:   if (rd_last) state_d = S_DONE;
        S_DONE:    state_d = S_RUN;
        S_STOP:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Avalon command decode: one bus operation per state, idle bus otherwise.
  always_comb begin
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 16'h0000;
    case (state_q)
      S_WR_PL: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_PERIOD_L;
        writedata  = period_q[15:0];
      end
      S_WR_PH: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_PERIOD_H;
        writedata  = period_q[31:16];
      end
      S_WR_CTRL: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_CONTROL;
        writedata  = CTRL_RUN;
      end
      S_CLR_ST: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_STATUS;
      end
      S_SNAP: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_SNAP_L;
      end
      S_RD_SL: begin
        chipselect = 1'b1;
        address    = ADDR_SNAP_L;
      end
      S_RD_SH: begin
        chipselect = 1'b1;
        address    = ADDR_SNAP_H;
      end
      S_STOP: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_CONTROL;
        writedata  = CTRL_STOP;
      end
      default: begin
        chipselect = 1'b0;
      end
    endcase
  end

  // Sequencer state, read-hold counter, pending stop and registered irq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      stop_pend_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register in the block samples pre-edge values, matching hardware.
      state_q     <= state_d;
      irq_q       <= timer_irq;
      stop_pend_q <= is_read && !rd_last && stop_req;
      if (is_read && !rd_last) begin
        rd_cnt_q <= rd_cnt_q + RC_W'(1);
      end else begin
        rd_cnt_q <= '0;
      end
    end
  end

  // Period latch: sampled only when a start is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= 32'h0000_0000;
    end else if (state_d == S_WR_PL) begin
      period_q <= cfg_period;
    end
  end

  // Snapshot halves are taken on the final cycle of each read window, when
  // the slave's registered readdata is valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_lo_q <= 16'h0000;
      snap_hi_q <= 16'h0000;
    end else begin
      if ((state_q == S_RD_SL) && rd_last) snap_lo_q <= readdata;
      if ((state_q == S_RD_SH) && rd_last) snap_hi_q <= readdata;
    end
  end

  // Service completion: publish snapshot, count the tick, pulse for one
  // cycle. A stop arriving in DONE preempts all three.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_pulse <= 1'b0;
      tick_count <= '0;
      snap_value <= 32'h0000_0000;
    end else begin
      tick_pulse <= 1'b0;
      if ((state_q == S_DONE) && (state_d == S_RUN)) begin
        tick_pulse <= 1'b1;
        tick_count <= tick_count + TICK_W'(1);
        snap_value <= {snap_hi_q, snap_lo_q};
      end
    end
  end

  // Running flag: set once START has been written; cleared when a reprogram
  // begins (period writes halt the timer) or once the STOP write is done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
    end else if ((state_q == S_WR_CTRL) && (state_d == S_RUN)) begin
      running <= 1'b1;
    end else if ((state_d == S_WR_PL) || (state_q == S_STOP)) begin
      running <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_irq_service_master.sv
// tb_timer_irq_service_master
// Self-checking bench: a behavioural timer slave answers the bus and raises
// the interrupt on request; a transaction-level model predicts the bus
// sequence, tick count and snapshot for each scenario.
module tb_timer_irq_service_master;

  localparam int TICK_W  = 4;
  localparam int RD_LAT  = 1;
  localparam int RD_CYC  = RD_LAT + 1;
  localparam int IRQ_LAT = 5 + 2 * RD_CYC;
  localparam int RV_W    = 3 + 1 + 1 + 16 + 3 + TICK_W + 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_start;
  logic              cmd_stop;
  logic [31:0]       cfg_period;
  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic              timer_irq;
  logic              busy;
  logic              running;
  logic              tick_pulse;
  logic [TICK_W-1:0] tick_count;
  logic [31:0]       snap_value;

  timer_irq_service_master #(.TICK_W(TICK_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_start  (cmd_start),
    .cmd_stop   (cmd_stop),
    .cfg_period (cfg_period),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .timer_irq  (timer_irq),
    .busy       (busy),
    .running    (running),
    .tick_pulse (tick_pulse),
    .tick_count (tick_count),
    .snap_value (snap_value)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [2:0]  a;
    logic [15:0] d;
  } bus_t;

  bus_t        bus_log[$];
  int unsigned bus_cyc[$];
  bus_t        exp_q[$];
  int unsigned cyc         = 0;
  int unsigned fire_cnt    = 0;
  int unsigned fire_done   = 0;
  int unsigned pulse_cnt   = 0;
  int unsigned proto_bad   = 0;
  logic [31:0] counter_val = 32'h0;
  logic [31:0] snap_reg;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_tick = 0;
  logic [31:0] exp_snap = 32'h0;

  // Timer slave model: logs every selected cycle, raises irq on request,
  // clears it on a status write, captures the counter on a snap write and
  // returns registered readdata one cycle after the address.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_irq <= 1'b0;
      readdata  <= 16'h0;
      snap_reg  <= 32'h0;
      fire_done <= fire_cnt;
    end else begin
      cyc <= cyc + 1;
      if (chipselect) begin
        bus_log.push_back(bus_t'{!write_n, address, write_n ? 16'h0 : writedata});
        bus_cyc.push_back(cyc);
      end
      if (!chipselect && !write_n) proto_bad <= proto_bad + 1;
      if (tick_pulse) pulse_cnt <= pulse_cnt + 1;
      if (chipselect && !write_n && address == 3'd0) begin
        timer_irq <= 1'b0;
      end else if (fire_cnt != fire_done) begin
        timer_irq <= 1'b1;
        fire_done <= fire_cnt;
      end
      if (chipselect && !write_n && address == 3'd4) snap_reg <= counter_val;
      if (chipselect && write_n && address == 3'd4)      readdata <= snap_reg[15:0];
      else if (chipselect && write_n && address == 3'd5) readdata <= snap_reg[31:16];
      else                                               readdata <= 16'h0;
    end
  end

  // Transaction-level model of what each high-level operation puts on the bus.
  task automatic model_start(input logic [31:0] p);
    exp_q.push_back(bus_t'{1'b1, 3'd2, p[15:0]});
    exp_q.push_back(bus_t'{1'b1, 3'd3, p[31:16]});
    exp_q.push_back(bus_t'{1'b1, 3'd1, 16'h0007});
  endtask

  task automatic model_service(input logic [31:0] snap, input bit completes);
    exp_q.push_back(bus_t'{1'b1, 3'd0, 16'h0000});
    exp_q.push_back(bus_t'{1'b1, 3'd4, 16'h0000});
    for (int i = 0; i < RD_CYC; i++) exp_q.push_back(bus_t'{1'b0, 3'd4, 16'h0000});
    if (completes) begin
      for (int i = 0; i < RD_CYC; i++) exp_q.push_back(bus_t'{1'b0, 3'd5, 16'h0000});
      exp_tick = (exp_tick + 1) % (1 << TICK_W);
      exp_snap = snap;
    end
  endtask

  task automatic model_stop();
    exp_q.push_back(bus_t'{1'b1, 3'd1, 16'h0008});
  endtask

  function automatic string fmt(input bus_t b);
    return $sformatf("%s(%0d,%04h)", b.wr ? "W" : "R", b.a, b.d);
  endfunction

  // Describes the first difference between the logged bus and exp_q; "" when equal.
  function automatic string bus_diff(input int mark);
    int n_got;
    n_got = bus_log.size() - mark;
    for (int i = 0; i < n_got || i < exp_q.size(); i++) begin
      if (i >= n_got)       return $sformatf("entry %0d got none want %s", i, fmt(exp_q[i]));
      if (i >= exp_q.size()) return $sformatf("entry %0d got %s want none", i, fmt(bus_log[mark + i]));
      if (bus_log[mark + i] !== exp_q[i])
        return $sformatf("entry %0d got %s want %s", i, fmt(bus_log[mark + i]), fmt(exp_q[i]));
    end
    return "";
  endfunction

  task automatic do_start(input logic [31:0] p, output int lat);
    cfg_period = p;
    cmd_start  = 1'b1;
    @(negedge clk);
    cmd_start  = 1'b0;
    lat = 1;
    while (running !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [RV_W-1:0] want;
    reset_n = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cfg_period = 32'h0;
    repeat (3) @(negedge clk);
    want = {3'd0, 1'b0, 1'b1, 16'h0, 3'b000, {TICK_W{1'b0}}, 32'h0};
    checks++;
    if ({address, chipselect, write_n, writedata, busy, running, tick_pulse, tick_count, snap_value} !== want) begin
      errors++;
      $display("FAIL reset_values: got %h want %h",
               {address, chipselect, write_n, writedata, busy, running, tick_pulse, tick_count, snap_value}, want);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start(input logic [31:0] p);
    int lat; int mark; string msg;
    mark = bus_log.size(); exp_q.delete(); model_start(p);
    do_start(p, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL start_latency: got %0d want 4", lat); end
    repeat (2) @(negedge clk);
    checks++; msg = bus_diff(mark);
    if (msg != "") begin errors++; $display("FAIL start_bus: %s", msg); end
    checks++;
    if (bus_log.size() < mark + 3 || bus_cyc[mark + 2] - bus_cyc[mark] !== 2) begin
      errors++; $display("FAIL start_consecutive: writes not on 3 consecutive cycles");
    end
    checks++;
    if ({running, busy} !== 2'b10) begin
      errors++; $display("FAIL start_flags: got running,busy=%b want 10", {running, busy});
    end
    checks++;
    if (tick_count !== TICK_W'(exp_tick)) begin
      errors++; $display("FAIL start_tick_kept: got %0d want %0d", tick_count, exp_tick);
    end
  endtask

  task automatic test_service(input logic [31:0] snap);
    int n; int mark; int unsigned p0; string msg;
    counter_val = snap;
    mark = bus_log.size(); exp_q.delete(); model_service(snap, 1'b1);
    p0 = pulse_cnt;
    fire_cnt++;
    n = 0;
    while (timer_irq !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (timer_irq !== 1'b1) begin errors++; $display("FAIL service_irq_rise: got %b want 1", timer_irq); end
    n = 0;
    while (tick_pulse !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n !== IRQ_LAT) begin errors++; $display("FAIL service_latency: got %0d want %0d", n, IRQ_LAT); end
    checks++;
    if (snap_value !== exp_snap) begin errors++; $display("FAIL service_snap: got %h want %h", snap_value, exp_snap); end
    checks++;
    if (tick_count !== TICK_W'(exp_tick)) begin
      errors++; $display("FAIL service_tick: got %0d want %0d", tick_count, exp_tick);
    end
    checks++;
    if (timer_irq !== 1'b0) begin errors++; $display("FAIL service_irq_cleared: got %b want 0", timer_irq); end
    @(negedge clk);
    checks++;
    if (tick_pulse !== 1'b0) begin errors++; $display("FAIL service_pulse_width: got %b want 0", tick_pulse); end
    repeat (2) @(negedge clk);
    checks++;
    if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL service_pulse_count: got %0d want 1", pulse_cnt - p0); end
    checks++; msg = bus_diff(mark);
    if (msg != "") begin errors++; $display("FAIL service_bus: %s", msg); end
  endtask

  task automatic test_back_to_back();
    int n; int mark; int unsigned p0; string msg; logic [31:0] snap;
    snap = $urandom;
    counter_val = snap;
    mark = bus_log.size(); exp_q.delete();
    model_service(snap, 1'b1); model_service(snap, 1'b1);
    p0 = pulse_cnt;
    fire_cnt++;
    n = 0; while (timer_irq !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    n = 0; while (timer_irq !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    fire_cnt++;
    n = 0; while (pulse_cnt - p0 < 2 && n < 80) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    checks++;
    if (pulse_cnt - p0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulse_cnt - p0); end
    checks++;
    if (tick_count !== TICK_W'(exp_tick)) begin
      errors++; $display("FAIL b2b_tick: got %0d want %0d", tick_count, exp_tick);
    end
    checks++; msg = bus_diff(mark);
    if (msg != "") begin errors++; $display("FAIL b2b_bus: %s", msg); end
  endtask

  task automatic test_wrap();
    while (exp_tick != (1 << TICK_W) - 1) test_service($urandom);
    checks++;
    if (tick_count !== {TICK_W{1'b1}}) begin errors++; $display("FAIL wrap_all_ones: got %0d", tick_count); end
    test_service($urandom);
    checks++;
    if (tick_count !== {TICK_W{1'b0}}) begin errors++; $display("FAIL wrap_zero: got %0d want 0", tick_count); end
  endtask

  task automatic test_stop_mid_read();
    int n; int mark; int unsigned p0; string msg; logic [31:0] snap;
    snap = $urandom;
    counter_val = snap;
    mark = bus_log.size(); exp_q.delete();
    model_service(snap, 1'b0); model_stop();
    p0 = pulse_cnt;
    fire_cnt++;
    n = 0;
    while (!(chipselect === 1'b1 && write_n === 1'b1 && address === 3'd4) && n < 30) begin
      @(negedge clk); n++;
    end
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    n = 0; while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    checks++; msg = bus_diff(mark);
    if (msg != "") begin errors++; $display("FAIL stop_read_bus: %s", msg); end
    checks++;
    if (pulse_cnt !== p0) begin errors++; $display("FAIL stop_read_pulse: got %0d pulses want 0", pulse_cnt - p0); end
    checks++;
    if ({tick_count, snap_value} !== {TICK_W'(exp_tick), exp_snap}) begin
      errors++; $display("FAIL stop_read_kept: got %0d/%h want %0d/%h", tick_count, snap_value, exp_tick, exp_snap);
    end
    checks++;
    if ({running, busy} !== 2'b00) begin errors++; $display("FAIL stop_read_idle: got running,busy=%b want 00", {running, busy}); end
  endtask

  task automatic test_start_in_wr_ph();
    int n; int mark; string msg; logic [31:0] p1;
    p1 = $urandom;
    mark = bus_log.size(); exp_q.delete(); model_start(p1);
    cfg_period = p1; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    @(negedge clk);
    cfg_period = ~p1; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    n = 0; while (running !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++; msg = bus_diff(mark);
    if (msg != "") begin errors++; $display("FAIL start_in_wr_ph_bus: %s", msg); end
    checks++;
    if ({running, busy} !== 2'b10) begin errors++; $display("FAIL start_in_wr_ph_run: got running,busy=%b want 10", {running, busy}); end
  endtask

  task automatic test_start_stop_same();
    int n; int mark; string msg;
    mark = bus_log.size(); exp_q.delete(); model_stop();
    cfg_period = $urandom; cmd_start = 1'b1; cmd_stop = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0; cmd_stop = 1'b0;
    n = 0; while (busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++; msg = bus_diff(mark);
    if (msg != "") begin errors++; $display("FAIL start_stop_same_bus: %s", msg); end
    checks++;
    if ({running, busy} !== 2'b00) begin errors++; $display("FAIL start_stop_same_idle: got running,busy=%b want 00", {running, busy}); end
  endtask

  task automatic test_reset_mid_rd_sh();
    int n; int lat; logic [RV_W-1:0] want;
    do_start($urandom, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL rst_prep_start: got latency %0d want 4", lat); end
    counter_val = $urandom;
    fire_cnt++;
    n = 0;
    while (!(chipselect === 1'b1 && write_n === 1'b1 && address === 3'd5) && n < 30) begin
      @(negedge clk); n++;
    end
    checks++;
    if (address !== 3'd5) begin errors++; $display("FAIL rst_reach_rd_sh: got addr %0d want 5", address); end
    #1 reset_n = 1'b0;
    #1;
    want = {3'd0, 1'b0, 1'b1, 16'h0, 3'b000, {TICK_W{1'b0}}, 32'h0};
    checks++;
    if ({address, chipselect, write_n, writedata, busy, running, tick_pulse, tick_count, snap_value} !== want) begin
      errors++;
      $display("FAIL rst_mid_rd_sh: got %h want %h",
               {address, chipselect, write_n, writedata, busy, running, tick_pulse, tick_count, snap_value}, want);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({chipselect, write_n} !== 2'b01) begin
        errors++; $display("FAIL rst_no_bus: got cs,write_n=%b want 01", {chipselect, write_n});
      end
    end
    exp_tick = 0; exp_snap = 32'h0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_start(32'h0001_869F);
    test_service(32'h0000_1234);
    for (int i = 0; i < 3; i++) test_service($urandom);
    test_back_to_back();
    test_start(32'h0000_0000);
    test_start($urandom);
    test_wrap();
    test_stop_mid_read();
    test_start_in_wr_ph();
    test_start_stop_same();
    test_reset_mid_rd_sh();
    test_start($urandom);
    test_service($urandom);
    checks++;
    if (proto_bad !== 0) begin errors++; $display("FAIL bus_protocol: got %0d bad cycles want 0", proto_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
